// File: rtl/fdd_track_loader_if.sv
// rtl/fdd_track_loader_if.sv - SD sector transfer handshake between track loader and hps_io port 0
interface fdd_track_loader_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/fdd_track_loader.sv
// rtl/fdd_track_loader.sv - loads a whole disk track from the SD image into the track buffer
// Optional FDD_WRITEBACK_EN: flushes a dirty track back to SD before loading another one.
module fdd_track_loader #(
  parameter int SECTORS = 13,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_size_nz,
  input  logic               img_readonly,
  input  logic               disk_wr,
  fdd_track_loader_if.master sd,
  output logic [3:0]         buf_sec,
  output logic               cpu_wait,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
`ifdef FDD_WRITEBACK_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
`endif
  localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

  logic [1:0]         state;
  logic [TRACK_W-1:0] loaded_track;
  logic [9:0]         base;
  logic               valid;
  logic               mount_pend;
  logic               req;
  logic               active;
  logic               load_req;
  logic [9:0]         track_base;
`ifdef FDD_WRITEBACK_EN
  logic               dirty;
  logic [9:0]         loaded_base;
  assign loaded_base = 10'(loaded_track) * 10'(SECTORS);
`else
  wire unused_wb = disk_wr ^ img_readonly;
`endif

  assign load_req   = mount_pend | ~valid | (track != loaded_track);
  assign track_base = 10'(track) * 10'(SECTORS);
  assign busy       = (state != ST_IDLE);
  assign sd.sd_lba  = {22'd0, base} + {28'd0, buf_sec};
  assign sd.sd_rd   = req & (state == ST_READ);
`ifdef FDD_WRITEBACK_EN
  assign sd.sd_wr   = req & (state == ST_FLUSH);
`else
  assign sd.sd_wr   = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      loaded_track <= '0;
      base         <= '0;
      buf_sec      <= '0;
      valid        <= 1'b0;
      mount_pend   <= 1'b0;
      req          <= 1'b0;
      active       <= 1'b0;
      cpu_wait     <= 1'b0;
`ifdef FDD_WRITEBACK_EN
      dirty        <= 1'b0;
`endif
    end else begin
      // A mount pulse is latched in any state; the IDLE load branch below consumes it.
      if (img_mounted)
        mount_pend <= 1'b1;
`ifdef FDD_WRITEBACK_EN
      if (disk_wr & ~img_readonly & valid)
        dirty <= 1'b1;
`endif
      if (state == ST_IDLE) begin
        if (load_req) begin
          mount_pend <= 1'b0;
          if (!img_size_nz) begin
            valid <= 1'b0;
          end else begin
            cpu_wait <= 1'b1;
            buf_sec  <= '0;
            req      <= 1'b0;
            active   <= 1'b0;
`ifdef FDD_WRITEBACK_EN
            if (dirty && !mount_pend) begin
              base  <= loaded_base;
              state <= ST_FLUSH;
            end else
`endif
            begin
              loaded_track <= track;
              base         <= track_base;
              state        <= ST_READ;
            end
          end
        end
      end else begin
        // Per-sector handshake: raise req, drop it on ack rise, advance on ack fall.
        if (!req && !active) begin
          req <= 1'b1;
        end else if (req && sd.sd_ack) begin
          req    <= 1'b0;
          active <= 1'b1;
        end else if (active && !sd.sd_ack) begin
          active <= 1'b0;
          if (buf_sec == LAST_SEC) begin
            if (state == ST_READ) begin
              valid    <= 1'b1;
              cpu_wait <= 1'b0;
              state    <= ST_IDLE;
`ifdef FDD_WRITEBACK_EN
              dirty    <= 1'b0;
`endif
            end
`ifdef FDD_WRITEBACK_EN
            else begin
              dirty        <= 1'b0;
              loaded_track <= track;
              base         <= track_base;
              buf_sec      <= '0;
              state        <= ST_READ;
            end
`endif
          end else begin
            buf_sec <= buf_sec + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fdd_track_loader.sv
// tb/tb_fdd_track_loader.sv - directed bench for fdd_track_loader with a behavioural SD responder
module tb_fdd_track_loader;
  logic       clk_sys = 1'b0;
  logic       reset;
  logic [5:0] track;
  logic       img_mounted, img_size_nz, img_readonly, disk_wr;
  logic [3:0] buf_sec;
  logic       cpu_wait, busy;

  fdd_track_loader_if sd_bus();

  fdd_track_loader #(.SECTORS(13), .TRACK_W(6)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .img_mounted(img_mounted),
    .img_size_nz(img_size_nz), .img_readonly(img_readonly), .disk_wr(disk_wr),
    .sd(sd_bus), .buf_sec(buf_sec), .cpu_wait(cpu_wait), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail = 0;
  bit log_wr[$];
  int log_lba[$];
  int log_sec[$];
  int ack_falls = 0;
  int wait_rises = 0;
  int resp_phase = 0;
  bit activity = 0;
  bit prev_wait = 0;

  // SD responder: logs each request, acks 2 cycles later for 4 cycles.
  initial begin
    int cnt, cur_lba, cur_sec;
    cnt = 0; cur_lba = 0; cur_sec = 0;
    sd_bus.sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        sd_bus.sd_ack = 1'b0;
        resp_phase = 0;
      end else if (resp_phase == 0) begin
        if (sd_bus.sd_rd || sd_bus.sd_wr) begin
          cur_lba = int'(sd_bus.sd_lba);
          cur_sec = int'(buf_sec);
          log_wr.push_back(sd_bus.sd_wr);
          log_lba.push_back(cur_lba);
          log_sec.push_back(cur_sec);
          cnt = 2;
          resp_phase = 1;
        end
      end else if (resp_phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          sd_bus.sd_ack = 1'b1;
          cnt = 4;
          resp_phase = 2;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          n_checks++;
          if (sd_bus.sd_lba !== 32'(cur_lba) || buf_sec !== 4'(cur_sec)) begin
            n_fail++;
            $display("FAIL lba_stable got lba=%0d sec=%0d expected lba=%0d sec=%0d",
                     sd_bus.sd_lba, buf_sec, cur_lba, cur_sec);
          end
          sd_bus.sd_ack = 1'b0;
          ack_falls++;
          resp_phase = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      #2;
      if (cpu_wait && !prev_wait) wait_rises++;
      prev_wait = cpu_wait;
      if (sd_bus.sd_rd || sd_bus.sd_wr || cpu_wait || busy) activity = 1;
    end
  end

  task automatic clear_logs();
    log_wr.delete(); log_lba.delete(); log_sec.delete();
    ack_falls = 0; wait_rises = 0; activity = 0;
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    bit done;
    quiet = 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_sys); #1;
      if (!busy && resp_phase == 0) quiet++; else quiet = 0;
      if (quiet >= 4) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout busy=%0d expected idle", name, busy);
    end
  endtask

  task automatic wait_log(input int n, input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_sys); #1;
      if (log_lba.size() >= n) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout log=%0d expected %0d", name, log_lba.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1; track = 0; img_mounted = 0; img_size_nz = 0; img_readonly = 0; disk_wr = 0;
    repeat (3) @(negedge clk_sys);
    #1 reset = 0;
    repeat (3) @(negedge clk_sys);
    #1;
    n_checks++;
    if (sd_bus.sd_lba !== 32'd0 || sd_bus.sd_rd !== 1'b0 || sd_bus.sd_wr !== 1'b0 ||
        buf_sec !== 4'd0 || cpu_wait !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got lba=%0d rd=%0d wr=%0d sec=%0d wait=%0d busy=%0d expected all 0",
               sd_bus.sd_lba, sd_bus.sd_rd, sd_bus.sd_wr, buf_sec, cpu_wait, busy);
    end
  endtask

  task automatic test_mount_load();
    bit done;
    clear_logs();
    @(negedge clk_sys);
    img_size_nz = 1; img_mounted = 1;
    @(negedge clk_sys);
    img_mounted = 0;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_sys); #1;
      if (ack_falls >= 13) done = 1;
    end
    n_checks++;
    if (!done || cpu_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL mount_wait_last got falls=%0d wait=%0d expected 13 1", ack_falls, cpu_wait);
    end
    @(negedge clk_sys); #1;
    n_checks++;
    if (cpu_wait !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mount_done got wait=%0d busy=%0d expected 0 0", cpu_wait, busy);
    end
    wait_idle("mount");
    n_checks++;
    if (log_lba.size() != 13 || wait_rises != 1) begin
      n_fail++;
      $display("FAIL mount_count got n=%0d rises=%0d expected 13 1", log_lba.size(), wait_rises);
    end
    for (int i = 0; i < 13 && i < log_lba.size(); i++) begin
      n_checks++;
      if (log_wr[i] !== 1'b0 || log_lba[i] != i || log_sec[i] != i) begin
        n_fail++;
        $display("FAIL mount_entry%0d got wr=%0d lba=%0d sec=%0d expected 0 %0d %0d",
                 i, log_wr[i], log_lba[i], log_sec[i], i, i);
      end
    end
  endtask

  task automatic test_track_change();
    clear_logs();
    track = 17;
    wait_idle("track17");
    n_checks++;
    if (log_lba.size() != 13 || wait_rises != 1) begin
      n_fail++;
      $display("FAIL t17_count got n=%0d rises=%0d expected 13 1", log_lba.size(), wait_rises);
    end
    for (int i = 0; i < 13 && i < log_lba.size(); i++) begin
      n_checks++;
      if (log_wr[i] !== 1'b0 || log_lba[i] != 221 + i || log_sec[i] != i) begin
        n_fail++;
        $display("FAIL t17_entry%0d got wr=%0d lba=%0d sec=%0d expected 0 %0d %0d",
                 i, log_wr[i], log_lba[i], log_sec[i], 221 + i, i);
      end
    end
  endtask

  task automatic test_change_mid_load();
    clear_logs();
    track = 5;
    wait_log(5, "mid_sec4");
    track = 6;
    wait_idle("mid");
    n_checks++;
    if (log_lba.size() != 26 || wait_rises != 2) begin
      n_fail++;
      $display("FAIL mid_count got n=%0d rises=%0d expected 26 2", log_lba.size(), wait_rises);
    end
    for (int i = 0; i < 26 && i < log_lba.size(); i++) begin
      n_checks++;
      if (log_wr[i] !== 1'b0 || log_lba[i] != 65 + i || log_sec[i] != i % 13) begin
        n_fail++;
        $display("FAIL mid_entry%0d got wr=%0d lba=%0d sec=%0d expected 0 %0d %0d",
                 i, log_wr[i], log_lba[i], log_sec[i], 65 + i, i % 13);
      end
    end
  endtask

  task automatic test_no_image();
    @(negedge clk_sys);
    img_size_nz = 0;
    clear_logs();
    img_mounted = 1;
    @(negedge clk_sys);
    img_mounted = 0;
    repeat (20) @(negedge clk_sys);
    #3;
    n_checks++;
    if (activity !== 1'b0 || log_lba.size() != 0) begin
      n_fail++;
      $display("FAIL no_image got activity=%0d n=%0d expected 0 0", activity, log_lba.size());
    end
  endtask

  task automatic test_reset_mid_load();
    bit done;
    track = 2;
    @(negedge clk_sys);
    clear_logs();
    img_size_nz = 1;
    wait_log(8, "rst_sec7");
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_sys); #1;
      if (resp_phase == 2) done = 1;
    end
    #3 reset = 1;
    #1;
    n_checks++;
    if (sd_bus.sd_rd !== 1'b0 || cpu_wait !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort got rd=%0d wait=%0d busy=%0d expected 0 0 0", sd_bus.sd_rd, cpu_wait, busy);
    end
    repeat (2) @(negedge clk_sys);
    n_checks++;
    if (sd_bus.sd_rd !== 1'b0 || cpu_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold got rd=%0d wait=%0d expected 0 0", sd_bus.sd_rd, cpu_wait);
    end
    clear_logs();
    #1 reset = 0;
    wait_idle("rst_reload");
    n_checks++;
    if (log_lba.size() != 13) begin
      n_fail++;
      $display("FAIL rst_count got n=%0d expected 13", log_lba.size());
    end
    for (int i = 0; i < 13 && i < log_lba.size(); i++) begin
      n_checks++;
      if (log_wr[i] !== 1'b0 || log_lba[i] != 26 + i || log_sec[i] != i) begin
        n_fail++;
        $display("FAIL rst_entry%0d got wr=%0d lba=%0d sec=%0d expected 0 %0d %0d",
                 i, log_wr[i], log_lba[i], log_sec[i], 26 + i, i);
      end
    end
  endtask

  task automatic test_writeback(input bit ro);
    int n_wr, n_exp, exp_lba, exp_sec;
    bit exp_wr;
`ifdef FDD_WRITEBACK_EN
    n_wr = ro ? 0 : 13;
`else
    n_wr = 0;
`endif
    n_exp = n_wr + 13;
    track = 3;
    wait_idle("wb_load3");
    clear_logs();
    img_readonly = ro;
    disk_wr = 1;
    @(negedge clk_sys);
    disk_wr = 0;
    track = 4;
    wait_idle("wb_load4");
    n_checks++;
    if (log_lba.size() != n_exp || wait_rises != 1) begin
      n_fail++;
      $display("FAIL wb%0d_count got n=%0d rises=%0d expected %0d 1", ro, log_lba.size(), wait_rises, n_exp);
    end
    for (int i = 0; i < n_exp && i < log_lba.size(); i++) begin
      exp_wr  = (i < n_wr);
      exp_lba = (i < n_wr) ? 39 + i : 52 + i - n_wr;
      exp_sec = (i < n_wr) ? i : i - n_wr;
      n_checks++;
      if (log_wr[i] !== exp_wr || log_lba[i] != exp_lba || log_sec[i] != exp_sec) begin
        n_fail++;
        $display("FAIL wb%0d_entry%0d got wr=%0d lba=%0d sec=%0d expected %0d %0d %0d",
                 ro, i, log_wr[i], log_lba[i], log_sec[i], exp_wr, exp_lba, exp_sec);
      end
    end
    img_readonly = 0;
  endtask

  initial begin
    test_reset();
    test_mount_load();
    test_track_change();
    test_change_mid_load();
    test_no_image();
    test_reset_mid_load();
    test_writeback(1'b0);
    test_writeback(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
